// File: rtl/audio_tx_pkg.sv
// Shared constants and types for the audio DAC transmit path (I2S, 64-bit frames).
package audio_tx_pkg;

  localparam int unsigned SLOT_W     = 32;
  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned MSB_POS    = 1;
  localparam int unsigned SAMPLE_W   = 24;

  typedef enum logic {
    LEFT_SLOT  = 1'b0,
    RIGHT_SLOT = 1'b1
  } lr_slot_e;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] left;
    logic signed [SAMPLE_W-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/audio_tx_fifo.sv
// Synchronous FIFO of stereo sample pairs with registered occupancy count.
module audio_tx_fifo
  import audio_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter type T = stereo_sample_t
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  T                         wdata,
  output T                         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/audio_dac_tx.sv
// I2S DAC transmitter: FIFO-buffered stereo pairs serialized on bclk/lrclk/data.
// Optional AUDIO_TX_UNDERFLOW_CNT_EN adds a saturating underflow_count output.
module audio_dac_tx
  import audio_tx_pkg::*;
#(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BCLK_DIV   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata_left,
  input  logic [DATA_W-1:0] writedata_right,
  output logic              write_ready,
  output logic              aud_bclk,
  output logic              aud_daclrck,
  output logic              aud_dacdat
`ifdef AUDIO_TX_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]       underflow_count
`endif
);

  localparam int unsigned DIV_W  = $clog2(BCLK_DIV);
  localparam int unsigned CNT_W  = $clog2(FRAME_BITS);
  localparam int unsigned POS_W  = $clog2(SLOT_W);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [FCNT_W-1:0] FULL_C   = FCNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic signed [DATA_W-1:0] left;
    logic signed [DATA_W-1:0] right;
  } pair_t;

  logic [DIV_W-1:0]  div_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_nxt;
  logic [POS_W-1:0]  pos_nxt;
  logic              div_wrap;
  logic              fall_evt;
  logic              frame_start;
  logic              in_data;
  pair_t             wdata;
  pair_t             head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_count;
  logic [DATA_W-1:0] sh_l;
  logic [DATA_W-1:0] sh_r;

  assign wdata       = {writedata_left, writedata_right};
  assign write_ready = (fifo_count != FULL_C);

  assign div_wrap    = (div_cnt == DIV_LAST);
  assign fall_evt    = div_wrap & aud_bclk;
  assign bit_nxt     = bit_cnt + 1'b1;
  assign pos_nxt     = bit_nxt[POS_W-1:0];
  assign frame_start = fall_evt && (bit_nxt == '0);
  assign in_data     = (32'(pos_nxt) >= MSB_POS) && (32'(pos_nxt) < MSB_POS + DATA_W);

  audio_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (pair_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (write & ~fifo_full),
    .pop     (frame_start),
    .wdata   (wdata),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // All data actions happen on the falling bclk event so the codec sees stable data on the rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      aud_bclk    <= 1'b0;
      aud_daclrck <= 1'b0;
      aud_dacdat  <= 1'b0;
      sh_l        <= '0;
      sh_r        <= '0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) aud_bclk <= ~aud_bclk;
      if (fall_evt) begin
        bit_cnt     <= bit_nxt;
        aud_daclrck <= bit_nxt[CNT_W-1];
        aud_dacdat  <= 1'b0;
        if (frame_start) begin
          sh_l <= fifo_empty ? '0 : head.left;
          sh_r <= fifo_empty ? '0 : head.right;
        end else if (in_data) begin
          if (lr_slot_e'(bit_nxt[CNT_W-1]) == RIGHT_SLOT) begin
            aud_dacdat <= sh_r[DATA_W-1];
            sh_r       <= sh_r << 1;
          end else begin
            aud_dacdat <= sh_l[DATA_W-1];
            sh_l       <= sh_l << 1;
          end
        end
      end
    end
  end

`ifdef AUDIO_TX_UNDERFLOW_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underflow_count <= '0;
    end else if (frame_start && fifo_empty && (underflow_count != '1)) begin
      underflow_count <= underflow_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_audio_dac_tx.sv
// Self-checking bench for audio_dac_tx: frame scoreboard plus directed corner sequences.
module tb_audio_dac_tx;
  localparam int unsigned DW        = 24;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned DIV       = 2;
  localparam int unsigned FRAME_CLK = 128 * DIV;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          write = 1'b0;
  logic [DW-1:0] wl = '0;
  logic [DW-1:0] wr = '0;
  logic          write_ready;
  logic          aud_bclk;
  logic          aud_daclrck;
  logic          aud_dacdat;
`ifdef AUDIO_TX_UNDERFLOW_CNT_EN
  logic [15:0]   underflow_count;
`endif

  always #5 clk = ~clk;

  audio_dac_tx #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .BCLK_DIV   (DIV)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .write           (write),
    .writedata_left  (wl),
    .writedata_right (wr),
    .write_ready     (write_ready),
    .aud_bclk        (aud_bclk),
    .aud_daclrck     (aud_daclrck),
    .aud_dacdat      (aud_dacdat)
`ifdef AUDIO_TX_UNDERFLOW_CNT_EN
    ,
    .underflow_count (underflow_count)
`endif
  );

  typedef struct {
    logic [31:0] lw;
    logic [31:0] rw;
    int unsigned cyc;
  } sb_t;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [31:0]   lw;
    logic [31:0]   rw;
  } vec_t;

  sb_t         q[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int unsigned fs_count = 0;
  int unsigned last_fs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] slot_word(input logic [DW-1:0] s);
    return {1'b0, s, 7'b0};
  endfunction

  // Frame monitor: capture 64 bits on rising bclk after each lrck 1->0, compare to scoreboard.
  initial begin
    logic        prev_bclk;
    logic        prev_lr;
    bit          armed;
    int unsigned pos;
    logic [63:0] cap_d;
    logic [63:0] cap_lr;
    logic [63:0] exp_d;
    sb_t         s;
    prev_bclk = 1'b0; prev_lr = 1'b0; armed = 1'b0; pos = 0;
    cap_d = '0; cap_lr = '0; exp_d = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        armed = 1'b0; prev_bclk = 1'b0; prev_lr = 1'b0; pos = 0;
      end else begin
        if (!aud_daclrck && prev_lr) begin
          fs_count++;
          last_fs = cyc;
          pos = 0;
          armed = 1'b1;
          if (q.size() > 0 && q[0].cyc < cyc) begin
            s = q.pop_front();
            exp_d = {s.lw, s.rw};
          end else begin
            exp_d = '0;
          end
        end
        if (aud_bclk && !prev_bclk && armed && pos < 64) begin
          cap_d[63-pos]  = aud_dacdat;
          cap_lr[63-pos] = aud_daclrck;
          pos++;
          if (pos == 64) begin
            chk("frame_data", cap_d, exp_d);
            chk("frame_lrck", cap_lr, {32'h0, 32'hFFFF_FFFF});
          end
        end
        prev_bclk = aud_bclk;
        prev_lr   = aud_daclrck;
      end
    end
  end

  task automatic wait_fs(input int unsigned n, output logic any_d);
    int unsigned start;
    int unsigned t;
    start = fs_count;
    t = 0;
    any_d = 1'b0;
    while (fs_count < start + n && t < (n + 1) * FRAME_CLK) begin
      any_d = any_d | aud_dacdat;
      @(negedge clk); #1;
      t++;
    end
    chk("frame_start_timeout", 64'(fs_count >= start + n), 64'd1);
  endtask

  task automatic do_write(input logic [DW-1:0] l, input logic [DW-1:0] r,
                          input logic [31:0] lw, input logic [31:0] rw, output logic acc);
    write = 1'b1;
    wl = l;
    wr = r;
    acc = write_ready;
    @(posedge clk); #1;
    write = 1'b0;
    if (acc) q.push_back('{lw: lw, rw: rw, cyc: cyc});
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    vec_t        vecs[6];
    logic        acc;
    logic        anyd;
    int unsigned f0;
`ifdef AUDIO_TX_UNDERFLOW_CNT_EN
    logic [15:0] u0;
`endif
    vecs[0] = '{l: 24'h800001, r: 24'h7FFFFE, lw: 32'h4000_0080, rw: 32'h3FFF_FF00};
    vecs[1] = '{l: 24'h000000, r: 24'hFFFFFF, lw: 32'h0000_0000, rw: 32'h7FFF_FF80};
    vecs[2] = '{l: 24'h123456, r: 24'hA5A5A5, lw: 32'h091A_2B00, rw: 32'h52D2_D280};
    vecs[3] = '{l: 24'hFFFFFF, r: 24'h000000, lw: 32'h7FFF_FF80, rw: 32'h0000_0000};
    vecs[4] = '{l: 24'h7FFFFE, r: 24'h800001, lw: 32'h3FFF_FF00, rw: 32'h4000_0080};
    vecs[5] = '{l: 24'hA5A5A5, r: 24'h123456, lw: 32'h52D2_D280, rw: 32'h091A_2B00};

    // Reset state
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_bclk", 64'(aud_bclk), 64'd0);
    chk("rst_lrck", 64'(aud_daclrck), 64'd0);
    chk("rst_dat", 64'(aud_dacdat), 64'd0);
    chk("rst_ready", 64'(write_ready), 64'd1);
`ifdef AUDIO_TX_UNDERFLOW_CNT_EN
    chk("rst_ufcnt", 64'(underflow_count), 64'd0);
`endif
    reset_n = 1'b1;

    // Table vectors queued during the initial zero frame
    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].l, vecs[i].r, vecs[i].lw, vecs[i].rw, acc);
      chk("tbl_accept", 64'(acc), 64'd1);
    end
    wait_fs(1, anyd);
    chk("frame0_zero", 64'(anyd), 64'd0);
`ifdef AUDIO_TX_UNDERFLOW_CNT_EN
    chk("frame0_no_uf", 64'(underflow_count), 64'd0);
`endif
    wait_fs(7, anyd);

    // Full: 9 back-to-back writes, 9th rejected
    for (int i = 0; i < 9; i++) begin
      logic [DW-1:0] l;
      logic [DW-1:0] r;
      l = DW'(32'h10_1010 * (i + 1));
      r = ~l;
      do_write(l, r, slot_word(l), slot_word(r), acc);
      chk("full_accept", 64'(acc), 64'(i < 8));
    end
    chk("full_ready_low", 64'(write_ready), 64'd0);
    wait_fs(1, anyd);
    chk("ready_after_pop", 64'(write_ready), 64'd1);
    wait_fs(9, anyd);

    // Underflow frames
`ifdef AUDIO_TX_UNDERFLOW_CNT_EN
    u0 = underflow_count;
`endif
    wait_fs(3, anyd);
    chk("uf_zero_data", 64'(anyd), 64'd0);
`ifdef AUDIO_TX_UNDERFLOW_CNT_EN
    chk("uf_count", 64'(underflow_count - u0), 64'd3);
`endif

    // Simultaneous write on the frame-start edge with one pair queued
    f0 = last_fs;
    do_write(24'hC0FFEE, 24'h0BEEF1, slot_word(24'hC0FFEE), slot_word(24'h0BEEF1), acc);
    chk("sim_accept_a", 64'(acc), 64'd1);
    while (cyc < f0 + FRAME_CLK - 1) begin
      @(negedge clk); #1;
    end
    do_write(24'h5A5A5A, 24'h3C3C3C, slot_word(24'h5A5A5A), slot_word(24'h3C3C3C), acc);
    chk("sim_accept_b", 64'(acc), 64'd1);
    wait_fs(1, anyd);
    chk("frame_period", 64'(last_fs - f0), 64'(FRAME_CLK));
    wait_fs(3, anyd);

    // Asynchronous reset at p=12 of the left slot with pairs queued
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] l;
      l = DW'(32'hF0_0F00 + i);
      do_write(l, ~l, slot_word(l), slot_word(~l), acc);
    end
    wait_fs(1, anyd);
    repeat (48) @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_bclk", 64'(aud_bclk), 64'd0);
    chk("mid_rst_lrck", 64'(aud_daclrck), 64'd0);
    chk("mid_rst_dat", 64'(aud_dacdat), 64'd0);
    chk("mid_rst_ready", 64'(write_ready), 64'd1);
    q.delete();
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;
`ifdef AUDIO_TX_UNDERFLOW_CNT_EN
    chk("mid_rst_ufcnt", 64'(underflow_count), 64'd0);
`endif
    wait_fs(1, anyd);
    chk("post_rst_frame0_zero", 64'(anyd), 64'd0);
    wait_fs(2, anyd);
    chk("post_rst_flushed", 64'(anyd), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
